// File: rtl/sync_filter_pkg.sv
// Shared constants and helpers for the multi-bit synchroniser/glitch filter.
// Holds the legal parameter limits and the filter counter width function.
package sync_filter_pkg;

  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 8;
  localparam int FILTER_CYCLES_MAX = 256;

  // Counter only has to reach FILTER_CYCLES-1; never narrower than 1 bit.
  function automatic int cnt_width(input int filter_cycles);
    return (filter_cycles <= 2) ? 1 : $clog2(filter_cycles);
  endfunction

endpackage

// File: rtl/sync_filter_nbit_if.sv
// Bundle of the synchroniser data/event signals.
//   ASYNC_IN  : asynchronous inputs (driven by master)
//   SYNC_OUT  : filtered synchronised levels
//   RISE/FALL : one-cycle per-channel edge pulses
//   CHANGED   : one-cycle pulse when any SYNC_OUT bit changes
// WIDTH must match the WIDTH of the sync_filter_nbit instance using it.
interface sync_filter_nbit_if #(parameter int WIDTH = 24);
  logic [WIDTH-1:0] ASYNC_IN;
  logic [WIDTH-1:0] SYNC_OUT;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic             CHANGED;

  modport master (output ASYNC_IN, input SYNC_OUT, RISE, FALL, CHANGED);
  modport slave  (input ASYNC_IN, output SYNC_OUT, RISE, FALL, CHANGED);
endinterface

// File: rtl/sync_filter_channel.sv
// One channel: SYNC_STAGES flop synchroniser, persistence filter and
// registered edge pulses.
//   clk, rst : destination clock, synchronous active-high reset
//   din      : asynchronous input bit
//   sync_out : accepted (filtered) level
//   rise/fall: one-cycle pulses on accepted 0->1 / 1->0 (0 unless
//              SYNC_FILTER_EDGE_EN is defined)
//   upd      : combinational "accepting this cycle", for the CHANGED reduction
module sync_filter_channel
  import sync_filter_pkg::*;
#(
  parameter int SYNC_STAGES   = 4,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall,
  output logic upd
);

  localparam int            CW       = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  // Metastability chain: keep flops adjacent, never pack into SRLs.
  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [SYNC_STAGES-1:0] sr;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s   = sr[SYNC_STAGES-1];
  assign upd = (s != sync_out) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      cnt      <= '0;
      sync_out <= 1'b0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], din};
      if (s == sync_out) begin
        cnt <= '0;               // back at accepted level: restart filter
      end else if (upd) begin
        sync_out <= s;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SYNC_FILTER_EDGE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= upd &  s;
      fall <= upd & ~s;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sync_filter_nbit.sv
// WIDTH-channel input synchroniser with per-channel glitch filter.
// Ports:
//   CLK : destination clock
//   RST : synchronous active-high reset
//   bus : sync_filter_nbit_if.slave (ASYNC_IN in; SYNC_OUT, RISE, FALL,
//         CHANGED out)
// Optional feature macro: SYNC_FILTER_EDGE_EN -- when defined RISE/FALL/
// CHANGED are generated; otherwise they are constant 0 with no flops.
// Channels resolve independently; not for coherent multi-bit buses.
module sync_filter_nbit
  import sync_filter_pkg::*;
#(
  parameter int WIDTH         = 24,
  parameter int SYNC_STAGES   = 4,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                CLK,
  input  logic                RST,
  sync_filter_nbit_if.slave   bus
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_filter_nbit: SYNC_STAGES out of range 2..8");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > FILTER_CYCLES_MAX) begin : g_bad_filter
    $error("sync_filter_nbit: FILTER_CYCLES out of range 1..256");
  end

  logic [WIDTH-1:0] out_v, rise_v, fall_v, upd_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .clk     (CLK),
      .rst     (RST),
      .din     (bus.ASYNC_IN[i]),
      .sync_out(out_v[i]),
      .rise    (rise_v[i]),
      .fall    (fall_v[i]),
      .upd     (upd_v[i])
    );
  end

  assign bus.SYNC_OUT = out_v;
  assign bus.RISE     = rise_v;
  assign bus.FALL     = fall_v;

`ifdef SYNC_FILTER_EDGE_EN
  logic changed;
  always_ff @(posedge CLK) begin
    if (RST) changed <= 1'b0;
    else     changed <= |upd_v;
  end
  assign bus.CHANGED = changed;
`else
  logic unused_upd;
  assign unused_upd  = ^upd_v;
  assign bus.CHANGED = 1'b0;
`endif

endmodule

// File: tb/tb_sync_filter_nbit.sv
// Directed bench for sync_filter_nbit at default parameters (24/4/4).
// Expected pulses are forced to 0 when SYNC_FILTER_EDGE_EN is not defined.
module tb_sync_filter_nbit;

  localparam int W = 24;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  sync_filter_nbit_if #(.WIDTH(W)) bus ();

  sync_filter_nbit #(.WIDTH(W), .SYNC_STAGES(4), .FILTER_CYCLES(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one edge, then compare all outputs against expectations.
  task automatic step(input string tag, input logic rst, input logic [W-1:0] din,
                      input logic [W-1:0] e_out, input logic [W-1:0] e_rise,
                      input logic [W-1:0] e_fall, input logic e_chg);
    RST          = rst;
    bus.ASYNC_IN = din;
    @(posedge CLK);
    #1;
`ifndef SYNC_FILTER_EDGE_EN
    e_rise = '0;
    e_fall = '0;
    e_chg  = 1'b0;
`endif
    chk({tag, ".out"},  32'(bus.SYNC_OUT), 32'(e_out));
    chk({tag, ".rise"}, 32'(bus.RISE),     32'(e_rise));
    chk({tag, ".fall"}, 32'(bus.FALL),     32'(e_fall));
    chk({tag, ".chg"},  32'(bus.CHANGED),  32'(e_chg));
  endtask

  localparam logic [W-1:0] ALL = 24'hFFFFFF;
  localparam logic [W-1:0] B0  = 24'h000001;
  localparam logic [W-1:0] B5  = 24'h000020;
  localparam logic [W-1:0] B23 = 24'h800000;
  localparam logic [W-1:0] Z   = 24'h000000;

  initial begin
    bus.ASYNC_IN = ALL;

    // 1: reset with all-ones input, release -> RISE everywhere at edge 7.
    step("rst0", 1'b1, ALL, Z, Z, Z, 1'b0);
    step("rst1", 1'b1, ALL, Z, Z, Z, 1'b0);
    for (int e = 0; e <= 8; e++) begin
      if (e < 7)       step("s1.wait", 1'b0, ALL, Z, Z, Z, 1'b0);
      else if (e == 7) step("s1.acc",  1'b0, ALL, ALL, ALL, Z, 1'b1);
      else             step("s1.post", 1'b0, ALL, ALL, Z, Z, 1'b0);
    end

    // Back to a clean all-zero state.
    step("rst2", 1'b1, Z, Z, Z, Z, 1'b0);

    // 2: 3-cycle glitch on bit 5 is rejected.
    for (int e = 0; e < 14; e++)
      step("s2.glitch", 1'b0, (e < 3) ? B5 : Z, Z, Z, Z, 1'b0);

    // 3: bit 5 high for 4 captures -> rise at edge 7, fall at edge 11.
    for (int e = 0; e < 14; e++) begin
      logic [W-1:0] eo;
      eo = (e >= 7 && e < 11) ? B5 : Z;
      step("s3.pulse", 1'b0, (e < 4) ? B5 : Z, eo,
           (e == 7) ? B5 : Z, (e == 11) ? B5 : Z, (e == 7 || e == 11));
    end

    // 4: bit 23 up first, then bit0 rises / bit23 falls on the same edge.
    for (int e = 0; e < 9; e++)
      step("s4.pre", 1'b0, B23, (e >= 7) ? B23 : Z,
           (e == 7) ? B23 : Z, Z, (e == 7));
    for (int e = 0; e < 10; e++) begin
      if (e < 7)       step("s4.wait", 1'b0, B0, B23, Z, Z, 1'b0);
      else if (e == 7) step("s4.swap", 1'b0, B0, B0, B0, B23, 1'b1);
      else             step("s4.post", 1'b0, B0, B0, Z, Z, 1'b0);
    end

    // 5: bit 5 pending, reset on edges 5 and 6 aborts it; full latency after.
    for (int e = 0; e < 16; e++) begin
      logic         r;
      logic [W-1:0] eo;
      r  = (e == 5 || e == 6);
      eo = (e < 5) ? B0 : ((e >= 14) ? (B0 | B5) : Z);
      step("s5.rst", r, B0 | B5, eo, (e == 14) ? (B0 | B5) : Z, Z, (e == 14));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_filter_nbit.md
# sync_filter_nbit

Parametrised multi-bit input synchroniser with a per-channel glitch filter and edge-pulse generation. Each of WIDTH asynchronous inputs passes through its own SYNC_STAGES flop chain into the CLK domain. It is then accepted only after holding a new value for FILTER_CYCLES consecutive cycles. It is the successor to the single-bit synchroniser and is used wherever slow external status or trigger lines enter the fabric and downstream logic needs clean levels and single-cycle change events.

## Interface
- WIDTH, 24: number of independent channels.
- SYNC_STAGES, 4: synchroniser flops per channel; legal range 2..8.
- FILTER_CYCLES, 4: consecutive cycles a new synchronised value must persist before acceptance; legal range 1..256.
- CLK  input  1  destination clock; all state is in this domain.
- RST  input  1  synchronous, active-high reset.
- ASYNC_IN  input  WIDTH  asynchronous inputs; channels are uncorrelated.
- SYNC_OUT  output  WIDTH  filtered, synchronised levels.
- RISE  output  WIDTH  one-cycle pulse when the corresponding SYNC_OUT bit goes 0→1.
- FALL  output  WIDTH  one-cycle pulse when the corresponding SYNC_OUT bit goes 1→0.
- CHANGED  output  1  one-cycle pulse when any SYNC_OUT bit changes.

## Operation
- Per channel: a shift chain sr[SYNC_STAGES-1:0] with sr[0] <= ASYNC_IN[i]. Its tap is s = sr[SYNC_STAGES-1]. Chain flops carry ASYNC_REG and have shift-register extraction disabled.
- Filter counter cnt, width clog2(FILTER_CYCLES), minimum 1 bit. Each cycle:
  - s == SYNC_OUT[i]: cnt <= 0.
  - s != SYNC_OUT[i] and cnt == FILTER_CYCLES-1: SYNC_OUT[i] <= s, cnt <= 0, and RISE[i] or FALL[i] <= 1 according to s.
  - s != SYNC_OUT[i] otherwise: cnt <= cnt+1.
- RISE/FALL/CHANGED are deasserted in every cycle with no update. They are registered, never combinational.
- CHANGED is registered as the OR of all channel update conditions in the same cycle.
- A disturbance at s shorter than FILTER_CYCLES cycles produces no SYNC_OUT change and no pulse. The counter restarts from 0 on each return to the accepted level.
- FILTER_CYCLES = 1 degenerates to a plain synchroniser plus one output register.
- Out-of-range parameters cause an elaboration-time error.

## Timing
- Reset: sr, cnt, SYNC_OUT, RISE, FALL and CHANGED are all 0 at the first edge with RST=1. This holds mid-operation too: an in-flight acceptance is aborted and no pulse is emitted during or after reset.
- Latency: for a stable input first captured into sr[0] at edge 0, SYNC_OUT updates at edge SYNC_STAGES+FILTER_CYCLES-1. The default setting is 7. Async sampling adds up to one cycle of uncertainty.
- RISE/FALL/CHANGED assert in the same cycle SYNC_OUT shows the new value, for exactly one cycle.
- Deasserting RST with ASYNC_IN[i]=1 yields a RISE[i] pulse after the normal latency.
- Simultaneous multi-channel updates assert all relevant RISE/FALL bits and a single-cycle CHANGED.
- Channels are not coherent with each other: a multi-bit input word changing at once may resolve on different cycles per bit. Coherent buses must use a handshake synchroniser instead.
- Minimum accepted toggle period at s: 2×FILTER_CYCLES cycles.

## Configuration
- SYNC_FILTER_EDGE_EN defined: RISE, FALL and CHANGED are generated as described.
- SYNC_FILTER_EDGE_EN not defined: RISE, FALL and CHANGED are tied to 0 with no edge flops. SYNC_OUT behaviour and latency are unchanged.

## Structure
- Shared package sync_filter_pkg:
  - SYNC_STAGES_MIN = 2, SYNC_STAGES_MAX = 8, FILTER_CYCLES_MAX = 256.
  - A function returning the counter width for a given FILTER_CYCLES.
- Sub-module sync_filter_channel: one chain, counter and edge logic. It is instantiated WIDTH times by a generate loop.
- The top level holds only the generate loop and the CHANGED reduction and register.

## Test plan
- Reset with ASYNC_IN=24'hFFFFFF, release RST -> all outputs 0 until edge 7 after release, then SYNC_OUT=24'hFFFFFF, RISE=24'hFFFFFF for one cycle, CHANGED=1 for one cycle.
- Bit 5 glitch high for 3 cycles (defaults) -> SYNC_OUT, RISE and CHANGED stay 0 throughout.
- Bit 5 held high for 4 cycles, then low -> SYNC_OUT[5] rises 7 cycles after capture and falls 7 cycles after the low is captured. One RISE[5] pulse and one FALL[5] pulse.
- Bit 0 rises and bit 23 falls on the same edge -> RISE[0] and FALL[23] coincide, with a single one-cycle CHANGED.
- RST asserted 2 cycles before a pending acceptance -> no pulse. After release with the input still high, the full 7-cycle latency is observed.
- Build without SYNC_FILTER_EDGE_EN, repeat scenario 3 -> identical SYNC_OUT; RISE/FALL/CHANGED constantly 0.
